key_debounce: RTL and testbench

//   Cleans one raw, bouncing, active-low push-button and produces a stable level plus

---
 rtl/key_debounce_pkg.sv | 12 +
 rtl/key_debounce_sync_2ff.sv | 34 +++
 rtl/key_debounce.sv | 155 +++++++++++++++
 tb/tb_key_debounce.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared board-level definitions for the key/LED path.
//   CLK_FREQ_HZ : board clock, also used by the LED/blink stage
//   ms_to_cnt   : terminal count of a counter that spans `ms` milliseconds
package key_debounce_pkg;

  localparam int CLK_FREQ_HZ = 12_000_000;

  function automatic int ms_to_cnt(input int clk_freq, input int ms);
    return clk_freq / 1000 * ms - 1;
  endfunction

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous pin.
//   clk, rst_n : clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronized output (RST_VAL while in reset)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, sync_q;
  logic meta_d, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_debounce.sv
// key_debounce: debounces one active-low push-button.
//   clk, rst_n  : clock, async active-low reset
//   key_n       : raw pin, 0 = pressed, asynchronous
//   key_level   : debounced level, 1 = held
//   key_press   : 1-cycle pulse per debounced press
//   key_release : 1-cycle pulse per debounced release
//   key_long    : 1-cycle pulse once per press after LONG_MS held
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int CLK_FREQ    = CLK_FREQ_HZ,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int CNT_DB   = ms_to_cnt(CLK_FREQ, DEBOUNCE_MS);
  localparam int CNT_LONG = ms_to_cnt(CLK_FREQ, LONG_MS);
  localparam int DB_W     = $clog2(CNT_DB + 1);
  localparam int LONG_W   = $clog2(CNT_LONG + 1);

  if (CNT_DB < 1 || CNT_LONG <= CNT_DB) begin : g_bad_params
    $error("key_debounce: need CNT_DB >= 1 and CNT_LONG > CNT_DB");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DOWN_WAIT = 2'd1,
    DOWN      = 2'd2,
    UP_WAIT   = 2'd3
  } state_t;

  logic ks;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_n),
    .q     (ks)
  );

  state_t              state_q, state_d;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic [LONG_W-1:0]   long_cnt_q, long_cnt_d;
  logic                long_done_q, long_done_d;
  logic                level_q, level_d;
  logic                press_q, press_d;
  logic                release_q, release_d;
  logic                long_q, long_d;
  logic                db_end, long_end;

  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    long_cnt_d  = long_cnt_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    db_end      = (db_cnt_q == DB_W'(CNT_DB));
    long_end    = (long_cnt_q == LONG_W'(CNT_LONG));

    // Hold timer runs while the key is debounced-down, including release
    // bounce. It saturates at CNT_LONG; long_done keeps key_long single-shot.
    if (state_q == DOWN || state_q == UP_WAIT) begin
      if (long_end) begin
        if (!long_done_q) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end
      end else begin
        long_cnt_d = long_cnt_q + LONG_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (!ks) begin
          state_d  = DOWN_WAIT;
          db_cnt_d = '0;
        end
      end
      DOWN_WAIT: begin
        if (ks) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_end) begin
          state_d     = DOWN;
          press_d     = 1'b1;
          level_d     = 1'b1;
          long_cnt_d  = '0;
          long_done_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      DOWN: begin
        if (ks) begin
          state_d  = UP_WAIT;
          db_cnt_d = '0;
        end
      end
      UP_WAIT: begin
        // A bounce back to DOWN keeps the hold timer: it is the same press.
        if (!ks) begin
          state_d  = DOWN;
          db_cnt_d = '0;
        end else if (db_end) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      long_cnt_q  <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      long_cnt_q  <= long_cnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with CNT_DB=4, CNT_LONG=49.
// Edge numbering: the first edge that samples a new key_n level is edge 1;
// the resulting press/release pulse is visible after edge 8 (CNT_DB+4).
module tb_key_debounce;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_n = 1'b1;
  logic key_level, key_press, key_release, key_long;

  int total = 0;
  int bad   = 0;
  int n_press = 0, n_rel = 0, n_long = 0;
  logic prev_p = 1'b0, prev_r = 1'b0, prev_l = 1'b0;

  always #5 clk = ~clk;

  key_debounce #(
    .CLK_FREQ    (1000),
    .DEBOUNCE_MS (5),
    .LONG_MS     (50)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_n       (key_n),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller has already driven key_n low; expects press after edge 8.
  task automatic press_latency(input string tag);
    for (int e = 1; e <= 7; e++) begin
      step();
      chk({tag, "_press_early"}, key_press, 1'b0);
      chk({tag, "_level_early"}, key_level, 1'b0);
    end
    step();
    chk({tag, "_press"}, key_press, 1'b1);
    chk({tag, "_level"}, key_level, 1'b1);
  endtask

  // Drives key_n high; expects release after edge 8.
  task automatic release_latency(input string tag);
    key_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk({tag, "_rel_early"}, key_release, 1'b0);
      chk({tag, "_lvl_held"}, key_level, 1'b1);
    end
    step();
    chk({tag, "_release"}, key_release, 1'b1);
    chk({tag, "_lvl_low"}, key_level, 1'b0);
  endtask

  // Event counters and single-cycle pulse check, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      n_press += int'(key_press);
      n_rel   += int'(key_release);
      n_long  += int'(key_long);
      total++;
      assert (!((key_press && prev_p) || (key_release && prev_r) || (key_long && prev_l)))
      else begin
        bad++;
        $error("FAIL pulse_width: observed=%b%b%b expected=single-cycle", key_press, key_release, key_long);
      end
    end
    prev_p = key_press;
    prev_r = key_release;
    prev_l = key_long;
  end

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_level", key_level, 1'b0);
    chk("rst_press", key_press, 1'b0);
    chk("rst_release", key_release, 1'b0);
    chk("rst_long", key_long, 1'b0);
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_level", key_level, 1'b0);

    // Test 2: five 3-cycle low glitches separated by 2 high cycles
    for (int g = 0; g < 5; g++) begin
      key_n = 1'b0;
      repeat (3) begin
        step();
        chk("t2_press", key_press, 1'b0);
        chk("t2_level", key_level, 1'b0);
      end
      key_n = 1'b1;
      repeat (2) step();
    end
    repeat (10) step();
    chki("t2_npress", n_press, 0);
    chk("t2_level_end", key_level, 1'b0);

    // Test 1: held low, press after edge 8
    key_n = 1'b0;
    press_latency("t1");
    step();  // P+1
    chk("t1_press_once", key_press, 1'b0);
    chk("t1_level_hold", key_level, 1'b1);
    chk("t3_long_p1", key_long, 1'b0);

    // Test 3: key_long exactly 50 cycles after key_press
    for (int k = 2; k <= 49; k++) begin
      step();
      chk("t3_long_early", key_long, 1'b0);
    end
    step();  // P+50
    chk("t3_long", key_long, 1'b1);
    repeat (50) step();  // P+100
    chki("t3_nlong", n_long, 1);
    chk("t3_level", key_level, 1'b1);

    // Test 4: release bounce high2/low1 x3, then stays high
    for (int r = 0; r < 3; r++) begin
      key_n = 1'b1;
      repeat (2) begin
        step();
        chk("t4_bounce_rel", key_release, 1'b0);
        chk("t4_bounce_lvl", key_level, 1'b1);
      end
      key_n = 1'b0;
      step();
      chk("t4_bounce_rel", key_release, 1'b0);
    end
    release_latency("t4");
    repeat (5) step();
    chki("t4_nrel", n_rel, 1);
    chki("t4_npress", n_press, 1);

    // Test 6: short press, no key_long, next press restarts hold timer
    key_n = 1'b0;
    press_latency("t6a");
    repeat (9) begin
      step();
      chk("t6_long_short", key_long, 1'b0);
    end
    release_latency("t6a");
    repeat (3) step();
    chki("t6_nlong", n_long, 1);
    chki("t6_nrel", n_rel, 2);
    key_n = 1'b0;
    press_latency("t6b");
    for (int k = 1; k <= 49; k++) begin
      step();
      chk("t6_long_early", key_long, 1'b0);
    end
    step();
    chk("t6_long", key_long, 1'b1);
    step();
    chki("t6_nlong2", n_long, 2);

    // Test 5a: reset in DOWN_WAIT with db_cnt=2
    release_latency("t5rel");
    repeat (3) step();
    key_n = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("t5a_level", key_level, 1'b0);
    chk("t5a_press", key_press, 1'b0);
    step();
    rst_n = 1'b1;
    press_latency("t5a");

    // Test 5b: reset in DOWN clears level immediately
    repeat (5) step();
    chk("t5b_pre_level", key_level, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5b_level", key_level, 1'b0);
    chk("t5b_press", key_press, 1'b0);
    chk("t5b_long", key_long, 1'b0);
    chk("t5b_release", key_release, 1'b0);
    step();
    chk("t5b_level_hold", key_level, 1'b0);
    rst_n = 1'b1;
    press_latency("t5b");
    step();
    chki("end_nrel", n_rel, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
